// File: rtl/board_eval_pkg.sv
// Shared definitions for the sequential board evaluator: FSM state codes,
// MAC feature-select codes and the output width helpers.
package board_eval_pkg;

  // FSM state codes
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] COL  = 2'd1;
  localparam logic [1:0] ROW  = 2'd2;
  localparam logic [1:0] MAC  = 2'd3;

  // Order in which features are fed through the shared multiplier
  localparam logic [2:0] F_MAX   = 3'd0;
  localparam logic [2:0] F_CUM   = 3'd1;
  localparam logic [2:0] F_REL   = 3'd2;
  localparam logic [2:0] F_ROUGH = 3'd3;
  localparam logic [2:0] F_HOLE  = 3'd4;
  localparam logic [2:0] F_CLR   = 3'd5;

  // Width able to hold any column height 0..rows
  function automatic int calc_hw(input int rows);
    return $clog2(rows + 1);
  endfunction

  // Width able to hold any board-wide count 0..rows*cols
  function automatic int calc_aw(input int rows, input int cols);
    return $clog2(rows * cols + 1);
  endfunction

endpackage

// File: rtl/board_eval_seq_column_profile.sv
// Combinational profile of one board column: height of the stack and
// the number of empty cells buried beneath its topmost filled cell.
module column_profile
  import board_eval_pkg::*;
#(
  parameter int ROWS = 20,
  localparam int HW = calc_hw(ROWS)
) (
  input  logic [ROWS-1:0] col_bits,
  output logic [HW-1:0]   h,
  output logic [HW-1:0]   col_holes
);

  logic seen;

  // Walk top to bottom; first set bit fixes the height, later zeros are holes
  always_comb begin
    h         = '0;
    col_holes = '0;
    seen      = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (seen && !col_bits[r]) begin
        col_holes = col_holes + HW'(1);
      end
      if (!seen && col_bits[r]) begin
        h    = HW'(ROWS - r);
        seen = 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_eval_seq.sv
// Multi-cycle Tetris board evaluator. Latches a board on start, scans it a
// column per cycle and a row per cycle, then accumulates a signed weighted
// score through one shared multiplier over six cycles.
module board_eval_seq
  import board_eval_pkg::*;
#(
  parameter int ROWS    = 20,
  parameter int COLS    = 10,
  parameter int SCORE_W = 32,
  parameter logic signed [SCORE_W-1:0] W_MAX   = -79112,
  parameter logic signed [SCORE_W-1:0] W_CUM   = -99462,
  parameter logic signed [SCORE_W-1:0] W_REL   = 65674,
  parameter logic signed [SCORE_W-1:0] W_ROUGH = -39506,
  parameter logic signed [SCORE_W-1:0] W_HOLE  = -86143,
  parameter logic signed [SCORE_W-1:0] W_CLR   = -44103,
  localparam int HW = calc_hw(ROWS),
  localparam int AW = calc_aw(ROWS, COLS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ROWS*COLS-1:0]      board,
  output logic                      busy,
  output logic                      done,
  output logic signed [SCORE_W-1:0] score,
  output logic [HW-1:0]             max_height,
  output logic [AW-1:0]             cum_height,
  output logic [HW-1:0]             rel_height,
  output logic [AW-1:0]             roughness,
  output logic [AW-1:0]             holes,
  output logic [HW-1:0]             cleared
);

  localparam int CW = $clog2(COLS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [1:0]                state;
  logic [ROWS*COLS-1:0]      shadow;
  logic [CW-1:0]             col_idx;
  logic [RW-1:0]             row_idx;
  logic [2:0]                mac_idx;

  logic [AW-1:0]             cum_acc;
  logic [AW-1:0]             hole_acc;
  logic [AW-1:0]             rough_acc;
  logic [HW-1:0]             max_acc;
  logic [HW-1:0]             min_acc;
  logic [HW-1:0]             h_prev;
  logic [HW-1:0]             clr_acc;
  logic signed [SCORE_W-1:0] acc;

  logic [ROWS-1:0]           col_bits;
  logic [HW-1:0]             col_h;
  logic [HW-1:0]             col_holes;
  logic [HW-1:0]             h_diff;
  logic                      row_full;
  logic [HW-1:0]             rel_val;
  logic [AW-1:0]             feat;
  logic signed [SCORE_W-1:0] feat_s;
  logic signed [SCORE_W-1:0] weight;
  logic signed [SCORE_W-1:0] prod;
  logic signed [SCORE_W-1:0] acc_next;

  assign busy = (state != IDLE);

  // Gather the column currently under scan from the shadow board
  always_comb begin
    col_bits = '0;
    for (int r = 0; r < ROWS; r++) begin
      col_bits[r] = shadow[COLS*r + int'(col_idx)];
    end
  end

  column_profile #(.ROWS(ROWS)) u_profile (
    .col_bits  (col_bits),
    .h         (col_h),
    .col_holes (col_holes)
  );

  assign h_diff   = (col_h >= h_prev) ? (col_h - h_prev) : (h_prev - col_h);
  assign row_full = &shadow[COLS*int'(row_idx) +: COLS];
  assign rel_val  = max_acc - min_acc;

  // Select the feature and its weight for the current multiply step
  always_comb begin
    feat   = '0;
    weight = '0;
    case (mac_idx)
      F_MAX:   begin feat = AW'(max_acc);   weight = W_MAX;   end
      F_CUM:   begin feat = cum_acc;        weight = W_CUM;   end
      F_REL:   begin feat = AW'(rel_val);   weight = W_REL;   end
      F_ROUGH: begin feat = rough_acc;      weight = W_ROUGH; end
      F_HOLE:  begin feat = hole_acc;       weight = W_HOLE;  end
      F_CLR:   begin feat = AW'(clr_acc);   weight = W_CLR;   end
      default: begin feat = '0;             weight = '0;      end
    endcase
  end

  assign feat_s   = SCORE_W'(feat);
  assign prod     = feat_s * weight;
  assign acc_next = acc + prod;

  // Evaluation sequencer: latch, column scan, row scan, multiply-accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shadow     <= '0;
      col_idx    <= '0;
      row_idx    <= '0;
      mac_idx    <= '0;
      cum_acc    <= '0;
      hole_acc   <= '0;
      rough_acc  <= '0;
      max_acc    <= '0;
      min_acc    <= '0;
      h_prev     <= '0;
      clr_acc    <= '0;
      acc        <= '0;
      done       <= 1'b0;
      score      <= '0;
      max_height <= '0;
      cum_height <= '0;
      rel_height <= '0;
      roughness  <= '0;
      holes      <= '0;
      cleared    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shadow    <= board;
            col_idx   <= '0;
            row_idx   <= '0;
            mac_idx   <= '0;
            cum_acc   <= '0;
            hole_acc  <= '0;
            rough_acc <= '0;
            max_acc   <= '0;
            min_acc   <= HW'(ROWS);
            h_prev    <= '0;
            clr_acc   <= '0;
            acc       <= '0;
            state     <= COL;
          end
        end
        COL: begin
          cum_acc  <= cum_acc + AW'(col_h);
          hole_acc <= hole_acc + AW'(col_holes);
          if (col_h > max_acc) max_acc <= col_h;
          if (col_h < min_acc) min_acc <= col_h;
          if (col_idx != '0) rough_acc <= rough_acc + AW'(h_diff);
          h_prev <= col_h;
          if (col_idx == CW'(COLS - 1)) begin
            row_idx <= '0;
            state   <= ROW;
          end else begin
            col_idx <= col_idx + CW'(1);
          end
        end
        ROW: begin
          if (row_full) clr_acc <= clr_acc + HW'(1);
          if (row_idx == RW'(ROWS - 1)) begin
            mac_idx <= F_MAX;
            state   <= MAC;
          end else begin
            row_idx <= row_idx + RW'(1);
          end
        end
        MAC: begin
          acc <= acc_next;
          if (mac_idx == F_CLR) begin
            state      <= IDLE;
            done       <= 1'b1;
            score      <= acc_next;
            max_height <= max_acc;
            cum_height <= cum_acc;
            rel_height <= rel_val;
            roughness  <= rough_acc;
            holes      <= hole_acc;
            cleared    <= clr_acc;
          end else begin
            mac_idx <= mac_idx + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_eval_seq.sv
// Self-checking bench for board_eval_seq: a latency-level reference model
// predicts busy/done/outputs every cycle from board features computed
// directly from the height/hole/line rules.
module tb_board_eval_seq;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int NB   = ROWS * COLS;
  localparam int LAT  = COLS + ROWS + 7;

  typedef struct {
    int mx;
    int cum;
    int rel;
    int rough;
    int hls;
    int clr;
    int score;
  } feat_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NB-1:0] board = '0;

  logic              busy;
  logic              done;
  logic signed [31:0] score;
  logic [4:0]        max_height;
  logic [7:0]        cum_height;
  logic [4:0]        rel_height;
  logic [7:0]        roughness;
  logic [7:0]        holes;
  logic [4:0]        cleared;

  int checks   = 0;
  int failures = 0;

  board_eval_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .board      (board),
    .busy       (busy),
    .done       (done),
    .score      (score),
    .max_height (max_height),
    .cum_height (cum_height),
    .rel_height (rel_height),
    .roughness  (roughness),
    .holes      (holes),
    .cleared    (cleared)
  );

  always #5 clk = ~clk;

  // Reference features straight from the board rules
  function automatic feat_t model(input logic [NB-1:0] b);
    feat_t f;
    int h[COLS];
    int mn;
    longint s;
    f.mx = 0; f.cum = 0; f.rough = 0; f.hls = 0; f.clr = 0;
    mn = ROWS;
    for (int c = 0; c < COLS; c++) begin
      int top;
      top = -1;
      for (int r = 0; r < ROWS; r++) begin
        if (b[COLS*r + c] && top < 0) top = r;
        else if (top >= 0 && !b[COLS*r + c]) f.hls++;
      end
      h[c] = (top < 0) ? 0 : ROWS - top;
      f.cum += h[c];
      if (h[c] > f.mx) f.mx = h[c];
      if (h[c] < mn) mn = h[c];
      if (c > 0) f.rough += (h[c] > h[c-1]) ? h[c] - h[c-1] : h[c-1] - h[c];
    end
    for (int r = 0; r < ROWS; r++) begin
      int full;
      full = 1;
      for (int c = 0; c < COLS; c++) if (!b[COLS*r + c]) full = 0;
      f.clr += full;
    end
    f.rel = f.mx - mn;
    s = longint'(f.mx) * -79112 + longint'(f.cum) * -99462 + longint'(f.rel) * 65674
      + longint'(f.rough) * -39506 + longint'(f.hls) * -86143 + longint'(f.clr) * -44103;
    f.score = int'(s);
    return f;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [NB-1:0] b);
    start = s;
    board = b;
  endtask

  // Latency-level model: accept when idle, results appear LAT-1 edges later
  int    m_cnt  = 0;
  logic  m_done = 1'b0;
  feat_t m_pend = '{0, 0, 0, 0, 0, 0, 0};
  feat_t m_exp  = '{0, 0, 0, 0, 0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_exp  <= '{0, 0, 0, 0, 0, 0, 0};
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_cnt  <= LAT - 1;
          m_pend <= model(board);
        end
      end else begin
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_exp  <= m_pend;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Every cycle, compare DUT against the model away from the active edge
  always @(negedge clk) begin
    checkOutput("busy",       longint'(busy),       longint'(m_cnt != 0));
    checkOutput("done",       longint'(done),       longint'(m_done));
    checkOutput("score",      longint'(score),      longint'(m_exp.score));
    checkOutput("max_height", longint'(max_height), longint'(m_exp.mx));
    checkOutput("cum_height", longint'(cum_height), longint'(m_exp.cum));
    checkOutput("rel_height", longint'(rel_height), longint'(m_exp.rel));
    checkOutput("roughness",  longint'(roughness),  longint'(m_exp.rough));
    checkOutput("holes",      longint'(holes),      longint'(m_exp.hls));
    checkOutput("cleared",    longint'(cleared),    longint'(m_exp.clr));
  end

  function automatic logic [NB-1:0] randBoard(input int mode);
    logic [NB-1:0] b;
    b = '0;
    if (mode == 0) begin
      int dens;
      dens = $urandom_range(5, 95);
      for (int i = 0; i < NB; i++) b[i] = ($urandom_range(0, 99) < dens);
    end else begin
      for (int c = 0; c < COLS; c++) begin
        int ht;
        ht = $urandom_range(0, ROWS);
        for (int r = ROWS - ht; r < ROWS; r++) b[COLS*r + c] = ($urandom_range(0, 99) < 80);
        if (ht > 0) b[COLS*(ROWS-ht) + c] = 1'b1;
      end
      for (int r = ROWS - 4; r < ROWS; r++)
        if ($urandom_range(0, 2) == 0)
          for (int c = 0; c < COLS; c++) b[COLS*r + c] = 1'b1;
    end
    return b;
  endfunction

  // Start one evaluation and wait for done; optionally disturb inputs mid-scan
  task automatic runEval(input logic [NB-1:0] b, input bit disturb,
                         output int lat, output int busyCnt, output int heldScore);
    applyStimulus(1'b1, b);
    @(posedge clk); #1;
    lat = 1;
    busyCnt = 0;
    heldScore = int'(score);
    applyStimulus(1'b0, disturb ? randBoard(0) : b);
    while (!done && lat < 200) begin
      if (busy) busyCnt++;
      if (lat == 20) heldScore = int'(score);
      @(posedge clk); #1;
      lat++;
      if (disturb) applyStimulus(lat == 5 || lat == 6, randBoard(0));
      else         applyStimulus(1'b0, b);
    end
    if (!done) checkOutput("done_timeout", 0, 1);
  endtask

  logic [NB-1:0] emptyB, rowB, cellB, fullB;
  int lat, bc, held;
  feat_t pin;

  initial begin
    emptyB = '0;
    rowB   = '0;
    for (int c = 0; c < COLS; c++) rowB[COLS*(ROWS-1) + c] = 1'b1;
    cellB    = '0;
    cellB[0] = 1'b1;
    fullB    = '1;

    // Pin the reference model against hand-computed scores
    pin = model(rowB);
    checkOutput("pin_row19_score", longint'(pin.score), -1117835);
    pin = model(cellB);
    checkOutput("pin_cell_score", longint'(pin.score), -4684837);
    checkOutput("pin_cell_holes", longint'(pin.hls), 19);
    pin = model(fullB);
    checkOutput("pin_full_clr", longint'(pin.clr), ROWS);
    checkOutput("pin_full_holes", longint'(pin.hls), 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", longint'(busy), 0);
    checkOutput("rst_done", longint'(done), 0);
    checkOutput("rst_score", longint'(score), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty board: latency, busy length, all-zero results
    runEval(emptyB, 1'b0, lat, bc, held);
    checkOutput("empty_latency", lat, 37);
    checkOutput("empty_busy_cycles", bc, 36);
    checkOutput("empty_score", longint'(score), 0);
    checkOutput("empty_rel", longint'(rel_height), 0);

    // Only bottom row full
    runEval(rowB, 1'b0, lat, bc, held);
    checkOutput("row19_score", longint'(score), -1117835);
    checkOutput("row19_cum", longint'(cum_height), 10);
    checkOutput("row19_cleared", longint'(cleared), 1);

    // Back-to-back: start in the done cycle; old results held meanwhile
    runEval(cellB, 1'b0, lat, bc, held);
    checkOutput("b2b_latency", lat, 37);
    checkOutput("b2b_held_score", longint'(held), -1117835);
    checkOutput("cell_score", longint'(score), -4684837);
    checkOutput("cell_max", longint'(max_height), 20);
    checkOutput("cell_rough", longint'(roughness), 20);

    // Board changes after latch and a second start mid-scan is ignored
    @(posedge clk); #1;
    runEval(rowB, 1'b1, lat, bc, held);
    checkOutput("disturb_latency", lat, 37);
    checkOutput("disturb_score", longint'(score), -1117835);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("disturb_no_second_done", longint'(busy), 0);

    // Full board
    runEval(fullB, 1'b0, lat, bc, held);
    checkOutput("full_cleared", longint'(cleared), ROWS);
    checkOutput("full_holes", longint'(holes), 0);

    // Reset pulse in the middle of the row scan
    @(posedge clk); #1;
    applyStimulus(1'b1, randBoard(1));
    @(posedge clk); #1;
    applyStimulus(1'b0, '0);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("midrst_busy", longint'(busy), 0);
    checkOutput("midrst_score", longint'(score), 0);
    checkOutput("midrst_cleared", longint'(cleared), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    // Randomized boards, mostly back-to-back
    for (int i = 0; i < 30; i++) begin
      runEval(randBoard(i % 2), 1'b0, lat, bc, held);
      checkOutput("rand_latency", lat, 37);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
      #0;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
